// File: rtl/rb_line_ctrl.sv
// Row-buffer sequencer: writes raster lines into rotating line BRAMs and issues shared-address
// reads of the stored lines once KERNEL-1 lines are buffered. Optional err output under RB_ERR_EN.
module rb_line_ctrl #(
    parameter int BRAMS       = 4,
    parameter int SEL_W       = 2,
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int LINE_WORDS  = 512,
    parameter int FRAME_LINES = 480,
    parameter int KERNEL      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              bram_w_en,
    output logic [SEL_W-1:0]  bram_w_sel,
    output logic [ADDR_W-1:0] bram_w_addr,
    output logic [DATA_W-1:0] bram_w_data,
    output logic              bram_r_en,
    output logic [ADDR_W-1:0] bram_r_addr,
    output logic              win_valid,
    output logic [DATA_W-1:0] win_live,
    output logic [SEL_W-1:0]  win_top_sel,
    output logic              busy,
    output logic              frame_done
`ifdef RB_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int LINE_W = (FRAME_LINES > 2) ? $clog2(FRAME_LINES) : 1;
    localparam int OFF    = KERNEL - 1;

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   col_reg, col_next;
    logic [LINE_W-1:0]   line_reg, line_next;
    logic [SEL_W-1:0]    w_sel_reg, w_sel_next;
    logic                win_valid_reg;
    logic [DATA_W-1:0]   win_live_reg;
    logic [SEL_W-1:0]    win_top_sel_reg;
    logic [SEL_W-1:0]    top_sel_next;
    logic                accept;
    logic                last_col;

    assign busy        = (state_reg == FILL) || (state_reg == STREAM);
    assign s_ready     = busy;
    assign frame_done  = (state_reg == DONE);
    assign accept      = s_valid && busy;
    assign last_col    = (col_reg == ADDR_W'(LINE_WORDS - 1));

    assign bram_w_en   = accept;
    assign bram_w_sel  = w_sel_reg;
    assign bram_w_addr = col_reg;
    assign bram_w_data = s_data;
    // Read shares the write column; the line being written is never one being read.
    assign bram_r_en   = accept && (state_reg == STREAM);
    assign bram_r_addr = col_reg;

    assign win_valid   = win_valid_reg;
    assign win_live    = win_live_reg;
    assign win_top_sel = win_top_sel_reg;

    // Oldest window line sits KERNEL-1 BRAMs behind the one being written, modulo BRAMS.
    always_comb begin
        if (int'(w_sel_reg) >= OFF)
            top_sel_next = SEL_W'(int'(w_sel_reg) - OFF);
        else
            top_sel_next = SEL_W'(int'(w_sel_reg) + BRAMS - OFF);
    end

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        line_next  = line_reg;
        w_sel_next = w_sel_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FILL;
                    col_next   = '0;
                    line_next  = '0;
                    w_sel_next = '0;
                end
            end
            FILL, STREAM: begin
                if (accept) begin
                    if (last_col) begin
                        col_next   = '0;
                        line_next  = line_reg + 1'b1;
                        w_sel_next = (w_sel_reg == SEL_W'(BRAMS - 1)) ? '0 : w_sel_reg + 1'b1;
                        if (state_reg == FILL && line_reg == LINE_W'(KERNEL - 2))
                            state_next = STREAM;
                        if (state_reg == STREAM && line_reg == LINE_W'(FRAME_LINES - 1))
                            state_next = DONE;
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                col_next   = '0;
                line_next  = '0;
                w_sel_next = '0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            line_reg  <= '0;
            w_sel_reg <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            line_reg  <= line_next;
            w_sel_reg <= w_sel_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_reg   <= 1'b0;
            win_live_reg    <= '0;
            win_top_sel_reg <= '0;
        end else begin
            win_valid_reg <= bram_r_en;
            if (bram_r_en) begin
                win_live_reg    <= s_data;
                win_top_sel_reg <= top_sel_next;
            end
        end
    end

`ifdef RB_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (state_reg == IDLE && start)
            err <= 1'b0;
        else if ((start && busy) || (s_valid && state_reg == IDLE))
            err <= 1'b1;
    end
`endif

endmodule
